// File: rtl/edge_detector_pkg.sv
// Shared definitions for the edge detector family (Mealy and Moore variants).
package edge_detector_pkg;

  // Per-bit history: the input level seen at the previous posedge.
  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } edge_state_t;

  // Depth of the optional input synchronizer.
  localparam int SYNC_STAGES = 2;

endpackage : edge_detector_pkg

// File: rtl/edge_detector_bit.sv
// Single-bit Mealy edge detector: one history FSM plus an optional
// input synchronizer.
// Build option: define EDGE_DETECTOR_SYNC_EN to insert a 2-flop synchronizer
// (reset to 0) ahead of the FSM; edges are then reported two cycles after the
// raw change and each pulse lasts exactly one full cycle.
module edge_detector_bit
  import edge_detector_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic positive_edge,
  output logic negative_edge
);

  logic        fsm_in;
  edge_state_t state_q;
  edge_state_t state_d;

`ifdef EDGE_DETECTOR_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign fsm_in = sync_q[SYNC_STAGES-1];
`else
  assign fsm_in = in;
`endif

  // History register: clears to S_LOW so a high input right after reset
  // is reported as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state simply tracks the level presented at the edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOW:   if (fsm_in)  state_d = S_HIGH;
      S_HIGH:  if (!fsm_in) state_d = S_LOW;
      default: state_d = S_LOW;
    endcase
  end

  // Mealy outputs from the current level and the history; reset forces
  // both low at once so a pulse in progress drops immediately.
  always_comb begin
    positive_edge = 1'b0;
    negative_edge = 1'b0;
    if (!rst) begin
      positive_edge = fsm_in  && (state_q == S_LOW);
      negative_edge = !fsm_in && (state_q == S_HIGH);
    end
  end

endmodule : edge_detector_bit

// File: rtl/edge_detector_mealy.sv
// Mealy edge detector, WIDTH independent bits. Zero-latency flags by default;
// define EDGE_DETECTOR_SYNC_EN to synchronize each input bit first.
module edge_detector_mealy #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] positive_edge,
  output logic [WIDTH-1:0] negative_edge
);

  // One fully independent detector per input bit.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    edge_detector_bit u_bit (
      .clk           (clk),
      .rst           (rst),
      .in            (in[g]),
      .positive_edge (positive_edge[g]),
      .negative_edge (negative_edge[g])
    );
  end

endmodule : edge_detector_mealy

// File: tb/tb_edge_detector_mealy.sv
// Directed bench for edge_detector_mealy (default build, no synchronizer).
module tb_edge_detector_mealy;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_s = '0;
  logic [W-1:0] pos;
  logic [W-1:0] neg;

  logic [W-1:0]   hist = '0;
  logic [2*W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int pulses0 = 0;
  int rise0 = 0;
  int fall0 = 0;

  edge_detector_mealy #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in            (in_s),
    .positive_edge (pos),
    .negative_edge (neg)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] v, input logic r,
                                           input logic [W-1:0] h);
    logic [W-1:0] p;
    logic [W-1:0] n;
    p = r ? '0 : (v & ~h);
    n = r ? '0 : (~v & h);
    return {p, n};
  endfunction

  task automatic check(input string tag);
    logic [2*W-1:0] e;
    logic [2*W-1:0] o;
    e = exp_q.pop_front();
    o = {pos, neg};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed pos/neg=%b expected %b", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // One full cycle: drive at negedge, check mid low phase, update model at posedge.
  task automatic step(input logic [W-1:0] v, input logic r, input string tag);
    @(negedge clk);
    in_s = v;
    rst  = r;
    exp_q.push_back(model(v, r, hist));
    #1;
    check(tag);
    pulses0 += int'(pos[0]) + int'(neg[0]);
    rise0   += int'(pos[0]);
    fall0   += int'(neg[0]);
    @(posedge clk);
    hist = r ? '0 : v;
  endtask

  // Input changes and returns inside one low phase: sub-cycle pulse, no state change.
  task automatic glitch(input logic [W-1:0] v, input string tag);
    logic [W-1:0] keep;
    @(negedge clk);
    keep = in_s;
    rst  = 1'b0;
    in_s = v;
    exp_q.push_back(model(v, 1'b0, hist));
    #1;
    check({tag, "_pulse"});
    in_s = keep;
    exp_q.push_back(model(keep, 1'b0, hist));
    #1;
    check({tag, "_restore"});
    @(posedge clk);
    hist = keep;
  endtask

  // Reset raised in the middle of a rising-edge pulse.
  task automatic mid_reset(input logic [W-1:0] v);
    @(negedge clk);
    rst  = 1'b0;
    in_s = v;
    exp_q.push_back(model(v, 1'b0, hist));
    #1;
    check("midrst_pulse");
    rst = 1'b1;
    exp_q.push_back(model(v, 1'b1, hist));
    #1;
    check("midrst_drop");
    @(posedge clk);
    hist = '0;
  endtask

  initial begin
    logic [W-1:0] cur;
    int d;
    int exp_edges;

    // Reset with input high: silent during reset, one rising pulse after release.
    step(2'b11, 1'b1, "rst_hold0");
    step(2'b11, 1'b1, "rst_hold1");
    step(2'b11, 1'b0, "rst_release_rise");
    step(2'b11, 1'b0, "held_high");
    step(2'b00, 1'b0, "fall_both");
    step(2'b00, 1'b0, "held_low");

    // Rising edge held for 5 cycles; bit 1 stays low throughout.
    step(2'b01, 1'b0, "rise_b0");
    for (int i = 0; i < 4; i++) step(2'b01, 1'b0, "rise_hold");

    // Falling edge, then a new rise proves the history went back to S_LOW.
    step(2'b00, 1'b0, "fall_b0");
    step(2'b00, 1'b0, "fall_hold");
    step(2'b10, 1'b0, "rise_b1_only");
    step(2'b01, 1'b0, "opposite_bits");
    step(2'b00, 1'b0, "fall_b0_after");

    // Toggle every cycle for 10 cycles: 5 rises and 5 falls, alternating.
    rise0 = 0;
    fall0 = 0;
    for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 2'b01 : 2'b00, 1'b0, "toggle");
    check_int("toggle_rises", rise0, 5);
    check_int("toggle_falls", fall0, 5);

    // Random hold times on bit 0; a zero delay is a double toggle inside one cycle.
    pulses0   = 0;
    exp_edges = 0;
    cur       = 2'b10;
    step(cur, 1'b0, "rand_setup");
    pulses0 = 0;
    for (int i = 0; i < 10; i++) begin
      d = (i == 3) ? 0 : int'($urandom_range(0, 127));
      if (d == 0) begin
        glitch(cur ^ 2'b01, "rand_glitch");
      end else begin
        cur = cur ^ 2'b01;
        exp_edges++;
        for (int k = 0; k < d; k++) step(cur, 1'b0, "rand_hold");
      end
    end
    check_int("rand_edge_count", pulses0, exp_edges);

    // Reset during a rising pulse, then re-report once after release.
    step(2'b00, 1'b0, "pre_midrst");
    mid_reset(2'b01);
    step(2'b01, 1'b1, "midrst_hold");
    step(2'b01, 1'b0, "midrst_rereport");
    step(2'b01, 1'b0, "midrst_steady");

    check_int("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_edge_detector_mealy
